// File: rtl/arp_cam_insert_ctrl.sv
// Insert controller for the 3-way set-associative ARP CAM: hash key to a set,
// read the three tags, pick a way (hit > first empty > random victim), write.
module arp_cam_insert_ctrl #(
    parameter int IDX_W = 8,
    parameter int KEY_W = 32,
    parameter int VAL_W = 48
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       InsValid,
    output logic                       InsReady,
    input  logic [KEY_W-1:0]           InsKey,
    input  logic [VAL_W-1:0]           InsVal,
    input  logic [1:0]                 RndMod,
    output logic                       TagRdEn,
    output logic [IDX_W-1:0]           TagRdAddr,
    input  logic [3*(1+KEY_W)-1:0]     TagRdData,
    output logic                       WrEn,
    output logic [IDX_W-1:0]           WrAddr,
    output logic [1:0]                 WrWay,
    output logic [KEY_W+VAL_W:0]       WrData,
    output logic                       DoneValid,
    output logic [1:0]                 DoneWay,
    output logic                       DoneHit,
    output logic                       DoneEvict
);
    localparam int TAG_W  = 1 + KEY_W;
    localparam int NSLICE = KEY_W / IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_CMP, S_WR} state_t;

    state_t             state, state_nx;
    logic [KEY_W-1:0]   key_q;
    logic [VAL_W-1:0]   val_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         way_q;
    logic               hit_q, evict_q;
    logic [IDX_W-1:0]   hash_idx;
    logic [2:0]         tag_vld, tag_hit;
    logic [1:0]         sel_way;
    logic               sel_hit, sel_evict;

    function automatic logic [1:0] lowest_set(input logic [2:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    // Set index folds every IDX_W-bit slice of the key together.
    always_comb begin
        hash_idx = '0;
        for (int i = 0; i < NSLICE; i++)
            hash_idx = hash_idx ^ InsKey[i*IDX_W +: IDX_W];
    end

    genvar w;
    generate
        for (w = 0; w < 3; w++) begin : g_way
            assign tag_vld[w] = TagRdData[w*TAG_W + KEY_W];
            assign tag_hit[w] = tag_vld[w] && (TagRdData[w*TAG_W +: KEY_W] == key_q);
        end
    endgenerate

    always_comb begin
        sel_way   = 2'd0;
        sel_hit   = 1'b0;
        sel_evict = 1'b0;
        if (|tag_hit) begin
            sel_way = lowest_set(tag_hit);
            sel_hit = 1'b1;
        end else if (~&tag_vld) begin
            sel_way = lowest_set(~tag_vld);
        end else begin
            // Random-modulo stage should never emit 3; fold it onto way 0 if it does.
            sel_way   = (RndMod == 2'd3) ? 2'd0 : RndMod;
            sel_evict = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (InsValid) state_nx = S_RD;
            S_RD:    state_nx = S_CMP;
            S_CMP:   state_nx = S_WR;
            S_WR:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            key_q   <= '0;
            val_q   <= '0;
            idx_q   <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
            evict_q <= 1'b0;
        end else begin
            if (state == S_IDLE && InsValid) begin
                key_q <= InsKey;
                val_q <= InsVal;
                idx_q <= hash_idx;
            end
            if (state == S_CMP) begin
                way_q   <= sel_way;
                hit_q   <= sel_hit;
                evict_q <= sel_evict;
            end
        end
    end

    // Done* fields come straight from the CMP registers so they hold between inserts.
    always_comb begin
        InsReady  = 1'b0;
        TagRdEn   = 1'b0;
        TagRdAddr = '0;
        WrEn      = 1'b0;
        WrAddr    = '0;
        WrWay     = '0;
        WrData    = '0;
        DoneValid = 1'b0;
        DoneWay   = way_q;
        DoneHit   = hit_q;
        DoneEvict = evict_q;
        case (state)
            S_IDLE: InsReady = 1'b1;
            S_RD: begin
                TagRdEn   = 1'b1;
                TagRdAddr = idx_q;
            end
            S_WR: begin
                WrEn      = 1'b1;
                WrAddr    = idx_q;
                WrWay     = way_q;
                WrData    = {1'b1, key_q, val_q};
                DoneValid = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
